// File: rtl/mem_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_scheduler
// Purpose  : Serialises I-cache, D-cache and DMA requests onto one 128-bit
//            memory port. Fixed priority D > I > DMA with starvation
//            promotion. DMA word writes become a line read-modify-write.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_scheduler #(
    parameter int ADDR_WIDTH   = 32,
    parameter int LINE_WIDTH   = 128,
    parameter int WORD_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] i_addr_i,
    input  logic [LINE_WIDTH-1:0] i_wdata_i,
    input  logic                  i_we_i,
    input  logic                  i_cs_i,
    output logic [LINE_WIDTH-1:0] i_rdata_o,
    output logic                  i_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [LINE_WIDTH-1:0] d_wdata_i,
    input  logic                  d_we_i,
    input  logic                  d_cs_i,
    output logic [LINE_WIDTH-1:0] d_rdata_o,
    output logic                  d_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] dma_addr_i,
    input  logic [WORD_WIDTH-1:0] dma_wdata_i,
    input  logic                  dma_we_i,
    input  logic                  dma_cs_i,
    output logic [WORD_WIDTH-1:0] dma_rdata_o,
    output logic                  dma_rvalid_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [LINE_WIDTH-1:0] wdata_o,
    output logic                  we_o,
    output logic                  cs_o,
    input  logic [LINE_WIDTH-1:0] rdata_i,
    input  logic                  rvalid_i,
    input  logic                  handshaked_i
);
    localparam int OFF_BITS  = $clog2(LINE_WIDTH / 8);
    localparam int WOFF_BITS = $clog2(WORD_WIDTH / 8);
    localparam int LANE_BITS = OFF_BITS - WOFF_BITS;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK  = ~ADDR_WIDTH'((1 << OFF_BITS) - 1);
    localparam logic [3:0]            STARVE_MAX = 4'(STARVE_LIMIT);
    // Requester ids double as bit positions in the pending/eligible vectors.
    localparam logic [1:0] ID_D   = 2'd0;
    localparam logic [1:0] ID_I   = 2'd1;
    localparam logic [1:0] ID_DMA = 2'd2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAIT     = 3'd2,
        RMW_REQ  = 3'd3,
        RMW_WAIT = 3'd4,
        RESP     = 3'd5
    } state_t;

    state_t                 state_q,      state_d;
    logic [1:0]             id_q,         id_d;
    logic [LANE_BITS-1:0]   lane_q,       lane_d;
    logic                   we_q,         we_d;
    logic [WORD_WIDTH-1:0]  dma_word_q,   dma_word_d;
    logic [LINE_WIDTH-1:0]  line_q,       line_d;
    logic                   excl_vld_q,   excl_vld_d;
    logic [1:0]             excl_id_q,    excl_id_d;
    logic [3:0]             starve_q [3];
    logic [3:0]             starve_d [3];
    logic                   mem_cs_q,     mem_cs_d;
    logic                   mem_we_q,     mem_we_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q,   mem_addr_d;
    logic [LINE_WIDTH-1:0]  mem_wdata_q,  mem_wdata_d;
    logic                   i_rvalid_q,   i_rvalid_d;
    logic                   d_rvalid_q,   d_rvalid_d;
    logic                   dma_rvalid_q, dma_rvalid_d;
    logic [LINE_WIDTH-1:0]  i_rdata_q,    i_rdata_d;
    logic [LINE_WIDTH-1:0]  d_rdata_q,    d_rdata_d;
    logic [WORD_WIDTH-1:0]  dma_rdata_q,  dma_rdata_d;

    logic [2:0]            pend, excl_mask, elig, starved, cand;
    logic [1:0]            win_id;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [LINE_WIDTH-1:0] win_wdata;
    logic                  win_we;
    logic [LINE_WIDTH-1:0] merged, resp_line;
    logic                  first_done, rmw_done, deliver;

    // Arbitration, transaction sequencing and registered-output next values.
    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        lane_d       = lane_q;
        we_d         = we_q;
        dma_word_d   = dma_word_q;
        line_d       = line_q;
        excl_vld_d   = excl_vld_q;
        excl_id_d    = excl_id_q;
        for (int k = 0; k < 3; k++) starve_d[k] = starve_q[k];
        mem_cs_d     = mem_cs_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_rvalid_d   = 1'b0;
        d_rvalid_d   = 1'b0;
        dma_rvalid_d = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        first_done   = 1'b0;
        rmw_done     = 1'b0;
        deliver      = 1'b0;
        resp_line    = line_q;

        // Starved requesters form a higher tier; inside a tier D > I > DMA.
        pend      = {dma_cs_i, i_cs_i, d_cs_i};
        excl_mask = excl_vld_q ? (3'b001 << excl_id_q) : 3'b000;
        elig      = pend & ~excl_mask;
        for (int k = 0; k < 3; k++) starved[k] = elig[k] && (starve_q[k] == STARVE_MAX);
        cand      = (|starved) ? starved : elig;
        if (cand[0])      win_id = ID_D;
        else if (cand[1]) win_id = ID_I;
        else              win_id = ID_DMA;

        case (win_id)
            ID_D: begin
                win_addr = d_addr_i;   win_wdata = d_wdata_i; win_we = d_we_i;
            end
            ID_I: begin
                win_addr = i_addr_i;   win_wdata = i_wdata_i; win_we = i_we_i;
            end
            default: begin
                win_addr  = dma_addr_i;
                win_wdata = {{(LINE_WIDTH-WORD_WIDTH){1'b0}}, dma_wdata_i};
                win_we    = dma_we_i;
            end
        endcase

        // Fetched line with the DMA word dropped into its lane.
        merged = rdata_i;
        merged[lane_q*WORD_WIDTH +: WORD_WIDTH] = dma_word_q;

        case (state_q)
            IDLE: begin
                // The exclusion only covers the first IDLE cycle after RESP.
                excl_vld_d = 1'b0;
                if (|elig) begin
                    id_d        = win_id;
                    lane_d      = win_addr[OFF_BITS-1:WOFF_BITS];
                    we_d        = win_we;
                    dma_word_d  = win_wdata[WORD_WIDTH-1:0];
                    mem_cs_d    = 1'b1;
                    mem_addr_d  = win_addr & LINE_MASK;
                    // A DMA access always starts with a plain line read.
                    mem_we_d    = win_we && (win_id != ID_DMA);
                    mem_wdata_d = (win_id == ID_DMA) ? '0 : win_wdata;
                    state_d     = REQ;
                    for (int k = 0; k < 3; k++) begin
                        if (elig[k]) begin
                            if (2'(k) == win_id)             starve_d[k] = 4'd0;
                            else if (starve_q[k] != STARVE_MAX) starve_d[k] = starve_q[k] + 4'd1;
                        end
                    end
                end
            end
            REQ: begin
                if (handshaked_i) begin
                    mem_cs_d = 1'b0;
                    state_d  = WAIT;
                    first_done = rvalid_i;
                end
            end
            WAIT:     first_done = rvalid_i;
            RMW_REQ: begin
                if (handshaked_i) begin
                    mem_cs_d = 1'b0;
                    state_d  = RMW_WAIT;
                    rmw_done = rvalid_i;
                end
            end
            RMW_WAIT: rmw_done = rvalid_i;
            RESP: begin
                state_d    = IDLE;
                excl_vld_d = 1'b1;
                excl_id_d  = id_q;
            end
            default:  state_d = IDLE;
        endcase

        if (first_done) begin
            line_d = rdata_i;
            if (id_q == ID_DMA && we_q) begin
                state_d     = RMW_REQ;
                mem_cs_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_wdata_d = merged;
            end else begin
                state_d   = RESP;
                deliver   = 1'b1;
                resp_line = rdata_i;
            end
        end
        // After a write-back the DMA requester gets the pre-merge lane.
        if (rmw_done) begin
            state_d   = RESP;
            deliver   = 1'b1;
            resp_line = line_q;
        end

        if (deliver) begin
            case (id_q)
                ID_D:    begin d_rvalid_d = 1'b1; d_rdata_d = resp_line; end
                ID_I:    begin i_rvalid_d = 1'b1; i_rdata_d = resp_line; end
                default: begin
                    dma_rvalid_d = 1'b1;
                    dma_rdata_d  = resp_line[lane_q*WORD_WIDTH +: WORD_WIDTH];
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            id_q         <= ID_D;
            lane_q       <= '0;
            we_q         <= 1'b0;
            dma_word_q   <= '0;
            line_q       <= '0;
            excl_vld_q   <= 1'b0;
            excl_id_q    <= ID_D;
            for (int k = 0; k < 3; k++) starve_q[k] <= 4'd0;
            mem_cs_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
            dma_rvalid_q <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            lane_q       <= lane_d;
            we_q         <= we_d;
            dma_word_q   <= dma_word_d;
            line_q       <= line_d;
            excl_vld_q   <= excl_vld_d;
            excl_id_q    <= excl_id_d;
            for (int k = 0; k < 3; k++) starve_q[k] <= starve_d[k];
            mem_cs_q     <= mem_cs_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_rvalid_q   <= i_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            dma_rvalid_q <= dma_rvalid_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign cs_o         = mem_cs_q;
    assign we_o         = mem_we_q;
    assign addr_o       = mem_addr_q;
    assign wdata_o      = mem_wdata_q;
    assign i_rvalid_o   = i_rvalid_q;
    assign d_rvalid_o   = d_rvalid_q;
    assign dma_rvalid_o = dma_rvalid_q;
    assign i_rdata_o    = i_rdata_q;
    assign d_rdata_o    = d_rdata_q;
    assign dma_rdata_o  = dma_rdata_q;

endmodule
`default_nettype wire
